mem_arbiter_top: RTL and testbench

MEM_ARBITER_TOP -- requirements
Module: mem_arbiter_top

---
 rtl/mem_arbiter_top.sv | 148 ++++++++++++++
 tb/tb_mem_arbiter_top.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter_top.sv
// Round-robin arbiter giving NUM_CH requesters access to one shared
// byte-maskable word memory, with a fixed per-access latency.
module mem_arbiter_top #(
  parameter int NUM_CH  = 2,
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 8,
  parameter int LATENCY = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_CH-1:0]          request,
  input  logic [NUM_CH-1:0]          we_re,
  input  logic [NUM_CH*DATA_W/8-1:0] mask,
  input  logic [NUM_CH*ADDR_W-1:0]   address,
  input  logic [NUM_CH*DATA_W-1:0]   data_in,
  output logic [NUM_CH-1:0]          gnt,
  output logic [NUM_CH-1:0]          valid,
  output logic [NUM_CH*DATA_W-1:0]   data_out,
  output logic                       busy
);

  localparam int NB    = DATA_W / 8;
  localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t            state_q, state_d;
  logic [1:0]        cnt_q, cnt_d;
  logic [CH_W-1:0]   ptr_q, ptr_d;
  logic [CH_W-1:0]   g_q;
  logic [CH_W-1:0]   pick;
  logic [CH_W:0]     idx;
  logic              pick_found;
  logic              grant_en;
  logic              access_en;

  logic              lat_we_q;
  logic [NB-1:0]     lat_mask_q;
  logic [ADDR_W-1:0] lat_addr_q;
  logic [DATA_W-1:0] lat_data_q;

  logic [NUM_CH-1:0] gnt_q, valid_q;
  logic [DATA_W-1:0] rdata_q [NUM_CH];
  logic [DATA_W-1:0] mem_q [DEPTH] = '{default: '0};

  // Rotating priority search from ptr; in RESP the channel just served is
  // excluded because its request is still high during its valid cycle.
  always_comb begin
    pick_found = 1'b0;
    pick       = '0;
    idx        = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      idx = {1'b0, ptr_q} + (CH_W+1)'(i);
      if (idx >= (CH_W+1)'(NUM_CH)) idx = idx - (CH_W+1)'(NUM_CH);
      if (!pick_found && request[idx[CH_W-1:0]] &&
          !(state_q == RESP && idx[CH_W-1:0] == g_q)) begin
        pick_found = 1'b1;
        pick       = idx[CH_W-1:0];
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    ptr_d     = ptr_q;
    grant_en  = 1'b0;
    access_en = 1'b0;
    case (state_q)
      IDLE, RESP: begin
        if (pick_found) begin
          grant_en = 1'b1;
          cnt_d    = 2'(LATENCY - 1);
          state_d  = ACCESS;
        end else begin
          state_d  = IDLE;
        end
      end
      ACCESS: begin
        if (cnt_q == 2'd0) begin
          access_en = 1'b1;
          state_d   = RESP;
          ptr_d     = (g_q == CH_W'(NUM_CH - 1)) ? '0 : g_q + 1'b1;
        end else begin
          cnt_d = cnt_q - 2'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      ptr_q      <= '0;
      g_q        <= '0;
      gnt_q      <= '0;
      valid_q    <= '0;
      lat_we_q   <= 1'b0;
      lat_mask_q <= '0;
      lat_addr_q <= '0;
      lat_data_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
      gnt_q   <= '0;
      valid_q <= '0;
      if (grant_en) begin
        g_q         <= pick;
        gnt_q[pick] <= 1'b1;
        lat_we_q    <= we_re[pick];
        lat_mask_q  <= mask[int'(pick)*NB +: NB];
        lat_addr_q  <= address[int'(pick)*ADDR_W +: ADDR_W];
        lat_data_q  <= data_in[int'(pick)*DATA_W +: DATA_W];
      end
      if (access_en) valid_q[g_q] <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int c = 0; c < NUM_CH; c++) rdata_q[c] <= '0;
    end else if (access_en && !lat_we_q) begin
      rdata_q[g_q] <= mem_q[lat_addr_q];
    end
  end

  // Memory is never cleared; an edge that coincides with reset must not write.
  always_ff @(posedge clk) begin
    if (access_en && lat_we_q && !rst) begin
      for (int b = 0; b < NB; b++) begin
        if (lat_mask_q[b]) mem_q[lat_addr_q][b*8 +: 8] <= lat_data_q[b*8 +: 8];
      end
    end
  end

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_dout
    assign data_out[gi*DATA_W +: DATA_W] = rdata_q[gi];
  end

  assign gnt   = gnt_q;
  assign valid = valid_q;
  assign busy  = (state_q != IDLE);

endmodule

// File: tb/tb_mem_arbiter_top.sv
// Directed bench for mem_arbiter_top: three instances (LATENCY 1, 3, 4)
// share the stimulus; each step observes only the instance it targets.
module tb_mem_arbiter_top;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req_r, we_r;
  logic [7:0]  mask_r;
  logic [15:0] addr_r;
  logic [63:0] din_r;

  logic [1:0]  gnt1, gnt3, gnt4, valid1, valid3, valid4;
  logic [63:0] dout1, dout3, dout4;
  logic        busy1, busy3, busy4;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_arbiter_top #(.NUM_CH(2), .DATA_W(32), .ADDR_W(8), .LATENCY(1)) dut1 (
    .clk(clk), .rst(rst), .request(req_r), .we_re(we_r), .mask(mask_r),
    .address(addr_r), .data_in(din_r), .gnt(gnt1), .valid(valid1),
    .data_out(dout1), .busy(busy1));

  mem_arbiter_top #(.NUM_CH(2), .DATA_W(32), .ADDR_W(8), .LATENCY(3)) dut3 (
    .clk(clk), .rst(rst), .request(req_r), .we_re(we_r), .mask(mask_r),
    .address(addr_r), .data_in(din_r), .gnt(gnt3), .valid(valid3),
    .data_out(dout3), .busy(busy3));

  mem_arbiter_top #(.NUM_CH(2), .DATA_W(32), .ADDR_W(8), .LATENCY(4)) dut4 (
    .clk(clk), .rst(rst), .request(req_r), .we_re(we_r), .mask(mask_r),
    .address(addr_r), .data_in(din_r), .gnt(gnt4), .valid(valid4),
    .data_out(dout4), .busy(busy4));

  function automatic logic [1:0] f_gnt(input int sel);
    case (sel)
      1:       return gnt1;
      3:       return gnt3;
      default: return gnt4;
    endcase
  endfunction

  function automatic logic [1:0] f_valid(input int sel);
    case (sel)
      1:       return valid1;
      3:       return valid3;
      default: return valid4;
    endcase
  endfunction

  function automatic logic f_busy(input int sel);
    case (sel)
      1:       return busy1;
      3:       return busy3;
      default: return busy4;
    endcase
  endfunction

  function automatic logic [31:0] f_dout(input int sel, input int ch);
    logic [63:0] v;
    case (sel)
      1:       v = dout1;
      3:       v = dout3;
      default: v = dout4;
    endcase
    return v[ch*32 +: 32];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst   = 1'b1;
    req_r = '0;
    tick();
    tick();
    rst   = 1'b0;
  endtask

  // One transaction on channel ch, observed on instance sel.
  task automatic do_txn(input int sel, input int lat, input int ch, input logic we,
                        input logic [3:0] m, input logic [7:0] a, input logic [31:0] d,
                        input bit chg, input logic [7:0] a2,
                        input logic [31:0] exp_rd, input string tag);
    int n;
    logic [1:0] oh;
    oh = '0;
    oh[ch] = 1'b1;
    req_r[ch]           = 1'b1;
    we_r[ch]            = we;
    mask_r[ch*4 +: 4]   = m;
    addr_r[ch*8 +: 8]   = a;
    din_r[ch*32 +: 32]  = d;
    tick();
    chk({tag, "/gnt"}, 64'(f_gnt(sel)), 64'(oh));
    chk({tag, "/busy"}, 64'(f_busy(sel)), 64'd1);
    if (chg) begin
      addr_r[ch*8 +: 8]  = a2;
      din_r[ch*32 +: 32] = ~d;
    end
    n = 1;
    while (f_valid(sel) === 2'b00 && n < 20) begin
      tick();
      n++;
    end
    chk({tag, "/latency"}, 64'(n), 64'(lat + 1));
    chk({tag, "/valid"}, 64'(f_valid(sel)), 64'(oh));
    if (!we) chk({tag, "/rdata"}, 64'(f_dout(sel, ch)), 64'(exp_rd));
    req_r[ch] = 1'b0;
    tick();
    chk({tag, "/valid_off"}, 64'(f_valid(sel)), 64'd0);
    chk({tag, "/idle"}, 64'(f_busy(sel)), 64'd0);
    $display("txn %s: dut L%0d ch%0d %s addr 0x%02h data 0x%08h mask 0x%h edges %0d",
             tag, lat, ch, we ? "WR" : "RD", a, we ? d : f_dout(sel, ch), m, n);
  endtask

  initial begin
    logic [1:0] exp_v, exp_g;
    int p;
    rst    = 1'b1;
    req_r  = '0;
    we_r   = '0;
    mask_r = '0;
    addr_r = '0;
    din_r  = '0;
    tick();
    tick();
    chk("rst/gnt", 64'(gnt1), 64'd0);
    chk("rst/valid", 64'(valid1), 64'd0);
    chk("rst/busy", 64'(busy1), 64'd0);
    chk("rst/dout", dout1, 64'd0);
    rst = 1'b0;

    // Directed transactions on the LATENCY=1 instance
    do_txn(1, 1, 1, 1'b1, 4'hF, 8'h10, 32'hDEADBEEF, 1'b0, 8'h00, 32'h0, "wr10");
    do_txn(1, 1, 0, 1'b0, 4'hF, 8'h10, 32'h0, 1'b0, 8'h00, 32'hDEADBEEF, "rd10");
    do_txn(1, 1, 1, 1'b1, 4'hF, 8'h05, 32'h11223344, 1'b0, 8'h00, 32'h0, "wr05");
    do_txn(1, 1, 1, 1'b1, 4'h2, 8'h05, 32'hAAAAAAAA, 1'b0, 8'h00, 32'h0, "wr05p");
    do_txn(1, 1, 1, 1'b0, 4'h0, 8'h05, 32'h0, 1'b0, 8'h00, 32'h1122AA44, "rd05");
    chk("rd05/ch0_hold", 64'(f_dout(1, 0)), 64'hDEADBEEF);
    do_txn(1, 1, 0, 1'b1, 4'hF, 8'h30, 32'h12345678, 1'b0, 8'h00, 32'h0, "wr30");
    do_txn(1, 1, 1, 1'b1, 4'h0, 8'h30, 32'hFFFFFFFF, 1'b0, 8'h00, 32'h0, "wr30m0");
    do_txn(1, 1, 0, 1'b0, 4'hF, 8'h30, 32'h0, 1'b0, 8'h00, 32'h12345678, "rd30");
    do_txn(1, 1, 0, 1'b1, 4'hF, 8'h01, 32'h00000101, 1'b0, 8'h00, 32'h0, "wr01");
    do_txn(1, 1, 0, 1'b1, 4'hF, 8'h02, 32'h00000202, 1'b0, 8'h00, 32'h0, "wr02");
    do_txn(1, 1, 0, 1'b0, 4'hF, 8'h01, 32'h0, 1'b1, 8'h02, 32'h00000101, "rd01chg");

    // Memory survives reset
    do_reset();
    chk("rst2/dout", dout1, 64'd0);
    do_txn(1, 1, 1, 1'b0, 4'hF, 8'h10, 32'h0, 1'b0, 8'h00, 32'hDEADBEEF, "rd10persist");

    // Both channels request continuously: alternating grants, ch0 first
    do_reset();
    we_r   = 2'b00;
    addr_r = {8'h05, 8'h10};
    req_r  = 2'b11;
    for (int k = 1; k <= 12; k++) begin
      tick();
      p = 2;
      exp_v = '0;
      exp_g = '0;
      if (k % p == 0) exp_v[((k / p) - 1) % 2] = 1'b1;
      if (k % p == 1) exp_g[((k - 1) / p) % 2] = 1'b1;
      chk($sformatf("rr1/valid@%0d", k), 64'(valid1), 64'(exp_v));
      chk($sformatf("rr1/gnt@%0d", k), 64'(gnt1), 64'(exp_g));
      p = 5;
      exp_v = '0;
      exp_g = '0;
      if (k % p == 0) exp_v[((k / p) - 1) % 2] = 1'b1;
      if (k % p == 1) exp_g[((k - 1) / p) % 2] = 1'b1;
      chk($sformatf("rr4/valid@%0d", k), 64'(valid4), 64'(exp_v));
      chk($sformatf("rr4/gnt@%0d", k), 64'(gnt4), 64'(exp_g));
    end
    chk("rr1/dout0", 64'(f_dout(1, 0)), 64'hDEADBEEF);
    chk("rr1/dout1", 64'(f_dout(1, 1)), 64'h1122AA44);
    $display("txn rr: 12 cycles of continuous requests on L1 and L4");

    // Reset in ACCESS on the LATENCY=3 instance aborts the write
    do_reset();
    req_r[1]        = 1'b1;
    we_r[1]         = 1'b1;
    mask_r[7:4]     = 4'hF;
    addr_r[15:8]    = 8'h20;
    din_r[63:32]    = 32'hCAFEBABE;
    tick();
    chk("abort/gnt", 64'(gnt3), 64'b10);
    tick();
    chk("abort/busy_pre", 64'(busy3), 64'd1);
    rst   = 1'b1;
    req_r = '0;
    #1;
    chk("abort/busy_async", 64'(busy3), 64'd0);
    chk("abort/valid_async", 64'(valid3), 64'd0);
    tick();
    chk("abort/valid_hold", 64'(valid3), 64'd0);
    tick();
    rst = 1'b0;
    tick();
    chk("abort/valid_after", 64'(valid3), 64'd0);
    $display("txn abort: L3 ch1 WR addr 0x20 reset during access");
    do_txn(3, 3, 0, 1'b0, 4'hF, 8'h20, 32'h0, 1'b0, 8'h00, 32'h00000000, "rd20");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
